// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin 4:1 mux arbiter: data width, requester
// count, FSM state encoding and pointer width.
package mux_arb_pkg;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/Mux4x1_16.sv
// Plain 16-bit 4:1 combinational multiplexer.
module Mux4x1_16 (
  input  logic [15:0] i_d0,
  input  logic [15:0] i_d1,
  input  logic [15:0] i_d2,
  input  logic [15:0] i_d3,
  input  logic [1:0]  i_sel,
  output logic [15:0] o_y
);
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      2'd3:    o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four requesters that captures the winner's data into
// a single-entry output register with a valid/ready handshake downstream.
module rr_mux4_arbiter #(
  parameter int WIDTH = mux_arb_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);
  import mux_arb_pkg::*;

  // Handshake: a word moves downstream on any edge where dout_valid && dout_ready;
  // dout/sel never change while dout_valid is high and dout_ready is low.
  // busy mirrors the FSM state (1 = HOLD) and serves as the state observation point.

  logic [0:0]       r_state;
  ptr_t             r_ptr;
  logic [3:0]       r_gnt;
  ptr_t             r_sel;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  logic [3:0]       w_eff;
  logic             w_any;
  logic             w_accept;
  ptr_t             w_arb_ptr;
  ptr_t             w_winner;
  logic             w_capture;
  logic [15:0]      w_mux_out;

  // Rotate so ptr+1 lands at bit 0, take the lowest set bit, rotate back.
  function automatic ptr_t rr_pick(input logic [NREQ-1:0] r, input ptr_t last);
    ptr_t              base;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    ptr_t              idx;
    base = last + ptr_t'(1);
    dbl  = {r, r};
    rot  = dbl[base +: NREQ];
    idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ptr_t'(i);
    end
    return idx + base;
  endfunction

  assign w_eff     = req & ~r_gnt;
  assign w_any     = |w_eff;
  assign w_accept  = (r_state == ST_HOLD) && r_dout_valid && dout_ready;
  // On an accept the pointer is about to become sel, so arbitrate from sel directly.
  assign w_arb_ptr = (r_state == ST_HOLD) ? r_sel : r_ptr;
  assign w_winner  = rr_pick(w_eff, w_arb_ptr);
  assign w_capture = w_any && ((r_state == ST_IDLE) || w_accept);

  Mux4x1_16 u_mux (
    .i_d0  (din0),
    .i_d1  (din1),
    .i_d2  (din2),
    .i_d3  (din3),
    .i_sel (w_winner),
    .o_y   (w_mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= ptr_t'(3);
      r_gnt        <= '0;
      r_sel        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_accept) r_ptr <= r_sel;
      if (w_capture) begin
        r_state      <= ST_HOLD;
        r_gnt        <= 4'b0001 << w_winner;
        r_sel        <= w_winner;
        r_dout       <= w_mux_out;
        r_dout_valid <= 1'b1;
      end else begin
        r_gnt <= '0;
        if (w_accept) begin
          r_state      <= ST_IDLE;
          r_dout_valid <= 1'b0;
        end
      end
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == ST_HOLD);
endmodule
